// File: rtl/ccff_loader_if.sv
// ccff_loader_if: operation control, word stream and configuration chain signals
// of the bitstream loader, seen from the controller (master) and the loader (slave).
interface ccff_loader_if #(
  parameter int BITSTREAM_SIZE = 1966,
  parameter int WORD_WIDTH     = 32,
  parameter int CNT_W          = $clog2(BITSTREAM_SIZE + 2)
);
  logic                  start;
  logic                  test_mode;
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;
  logic                  ccff_head;
  logic                  ccff_tail;
  logic                  config_enable;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [CNT_W-1:0]      shift_count;

  modport master (
    output start, test_mode, word_data, word_valid, ccff_tail,
    input  word_ready, ccff_head, config_enable, busy, done, error, shift_count
  );

  modport slave (
    input  start, test_mode, word_data, word_valid, ccff_tail,
    output word_ready, ccff_head, config_enable, busy, done, error, shift_count
  );
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: streams configuration words MSB-first into the fabric configuration
// chain, or runs a single-marker self-test that checks the chain length.
module ccff_loader #(
  parameter int BITSTREAM_SIZE = 1966,
  parameter int WORD_WIDTH     = 32,
  parameter int CNT_W          = $clog2(BITSTREAM_SIZE + 2)
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  ccff_loader_if.slave bus
);
  localparam int REQ_W  = $clog2(BITSTREAM_SIZE + WORD_WIDTH + 1);
  localparam int BITS_W = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(BITSTREAM_SIZE);
  localparam logic [CNT_W-1:0]  LAST_M1   = CNT_W'(BITSTREAM_SIZE - 1);
  localparam logic [REQ_W-1:0]  REQ_LIMIT = REQ_W'(BITSTREAM_SIZE);
  localparam logic [REQ_W-1:0]  REQ_STEP  = REQ_W'(WORD_WIDTH);
  localparam logic [BITS_W-1:0] FULL_BITS = BITS_W'(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, PROG, TEST, FIN} state_t;
  state_t state, state_next;

  logic [WORD_WIDTH-1:0] shift_reg, hold_reg;
  logic [BITS_W-1:0]     shift_bits;
  logic                  hold_full;
  logic [REQ_W-1:0]      requested;
  logic [CNT_W-1:0]      launched, cnt;
  logic                  head, cfg_en, err;
  logic                  accept_start, launch, early_stop, test_end, take_word, count_en;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    launch       = 1'b0;
    early_stop   = 1'b0;
    test_end     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_start = 1'b1;
          state_next   = bus.test_mode ? TEST : PROG;
        end
      end
      PROG: begin
        if (launched == LAST) state_next = FIN;
        else                  launch = (shift_bits != '0) || hold_full;
      end
      TEST: begin
        if (cnt == LAST) begin
          test_end   = 1'b1;
          state_next = FIN;
        end else if ((cnt != '0) && bus.ccff_tail) begin
          early_stop = 1'b1;
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.word_ready = (state == PROG) && !hold_full && (requested < REQ_LIMIT);
  assign take_word      = bus.word_ready && bus.word_valid;
  // The shift coinciding with early-marker detection is aborted and not counted.
  assign count_en       = cfg_en && (cnt != LAST) && !early_stop;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shift_reg  <= '0;
      hold_reg   <= '0;
      shift_bits <= '0;
      hold_full  <= 1'b0;
      requested  <= '0;
      launched   <= '0;
      cnt        <= '0;
      head       <= 1'b0;
      cfg_en     <= 1'b0;
      err        <= 1'b0;
    end else begin
      cfg_en <= 1'b0;
      if (count_en) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (accept_start) begin
            err       <= 1'b0;
            cnt       <= '0;
            launched  <= '0;
            requested <= '0;
          end
        end
        PROG: begin
          if (launch) begin
            cfg_en   <= 1'b1;
            launched <= launched + 1'b1;
            if (shift_bits != '0) begin
              head <= shift_reg[WORD_WIDTH-1];
              if ((shift_bits == BITS_W'(1)) && hold_full) begin
                shift_reg  <= hold_reg;
                shift_bits <= FULL_BITS;
                hold_full  <= 1'b0;
              end else begin
                shift_reg  <= shift_reg << 1;
                shift_bits <= shift_bits - 1'b1;
              end
            end else begin
              // Shift register drained: launch straight from the holding register.
              head       <= hold_reg[WORD_WIDTH-1];
              shift_reg  <= hold_reg << 1;
              shift_bits <= FULL_BITS - 1'b1;
              hold_full  <= 1'b0;
            end
          end
          if (take_word) begin
            hold_reg  <= bus.word_data;
            hold_full <= 1'b1;
            requested <= requested + REQ_STEP;
          end
        end
        TEST: begin
          if (test_end) begin
            err <= !bus.ccff_tail;
          end else if (early_stop) begin
            err <= 1'b1;
          end else begin
            cfg_en <= !(cfg_en && (cnt == LAST_M1));
            head   <= (cnt == '0) && !cfg_en;
          end
        end
        FIN: begin
          shift_bits <= '0;
          hold_full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ccff_head     = head;
  assign bus.config_enable = cfg_en;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == FIN);
  assign bus.error         = err;
  assign bus.shift_count   = cnt;
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed bench for ccff_loader with a behavioural configuration
// chain model and scoreboards of accepted words and expected self-test results.
module tb_ccff_loader;
  localparam int BS     = 1966;
  localparam int WW     = 32;
  localparam int CW     = $clog2(BS + 2);
  localparam int NWORDS = (BS + WW - 1) / WW;

  typedef struct packed {
    logic          err;
    logic [CW-1:0] cnt;
  } result_t;

  logic prog_clk = 1'b0;
  logic prog_reset;
  always #5 prog_clk = ~prog_clk;

  ccff_loader_if #(.BITSTREAM_SIZE(BS), .WORD_WIDTH(WW), .CNT_W(CW)) bus ();

  ccff_loader #(.BITSTREAM_SIZE(BS), .WORD_WIDTH(WW), .CNT_W(CW)) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .bus       (bus)
  );

  logic [BS-1:0] chain;
  logic          chain_clear;
  int            chain_len;
  logic          tail_broken;
  int            cyc = 0;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Configuration chain: shifts head in at every enabled edge.
  always @(posedge prog_clk) begin
    if (chain_clear)             chain <= '0;
    else if (bus.config_enable)  chain <= {chain[BS-2:0], bus.ccff_head};
  end
  assign bus.ccff_tail = tail_broken ? 1'b0 : chain[chain_len-1];

  logic [WW-1:0] words [NWORDS];
  logic [WW-1:0] word_q [$];
  result_t       res_q [$];
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic tm);
    @(negedge prog_clk);
    bus.start     = 1'b1;
    bus.test_mode = tm;
    @(negedge prog_clk);
    bus.start     = 1'b0;
  endtask

  task automatic clear_chain(input int len);
    chain_len   = len;
    tail_broken = 1'b0;
    @(negedge prog_clk);
    chain_clear = 1'b1;
    @(negedge prog_clk);
    chain_clear = 1'b0;
  endtask

  task automatic check_reset_abort(input string name);
    bit saw_done = 1'b0;
    prog_reset     = 1'b1;
    bus.word_valid = 1'b0;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    check_output({name, "_enable"}, bus.config_enable, 0);
    check_output({name, "_busy"},   bus.busy, 0);
    check_output({name, "_ready"},  bus.word_ready, 0);
    check_output({name, "_done"},   bus.done, 0);
    repeat (4) begin
      @(negedge prog_clk);
      if (bus.done) saw_done = 1'b1;
    end
    check_output({name, "_no_late_done"}, saw_done, 0);
  endtask

  task automatic run_test(input string name, input int len, input bit broken,
                          input bit exp_err, input int exp_cnt);
    int      high    = 0;
    int      done_at = -1;
    result_t r;
    clear_chain(len);
    tail_broken = broken;
    r.err = exp_err;
    r.cnt = CW'(exp_cnt);
    res_q.push_back(r);
    apply_stimulus(1'b1);
    check_output({name, "_busy"}, bus.busy, 1);
    @(negedge prog_clk);
    check_output({name, "_first_enable"}, bus.config_enable, 1);
    check_output({name, "_first_head"},   bus.ccff_head, 1);
    for (int c = 0; c < 2 * BS && done_at < 0; c++) begin
      if (bus.done) done_at = cyc;
      else begin
        if (bus.config_enable) high++;
        @(negedge prog_clk);
      end
    end
    check_output({name, "_done_seen"},     done_at >= 0, 1);
    check_output({name, "_enable_cycles"}, high, BS);
    r = res_q.pop_front();
    check_output({name, "_error"}, bus.error, r.err);
    check_output({name, "_count"}, bus.shift_count, r.cnt);
    // A start arriving together with done must be ignored.
    bus.start     = 1'b1;
    bus.test_mode = 1'b1;
    @(negedge prog_clk);
    bus.start = 1'b0;
    check_output({name, "_start_at_done_ignored"}, bus.busy, 0);
    check_output({name, "_error_sticky"}, bus.error, r.err);
  endtask

  task automatic run_prog(input string name, input int gap_word, input int gap_len,
                          input int exp_stall, input int reset_at);
    int            idx = 0, gap_left = 0, first = -1, done_at = -1, xfer0 = -1;
    int            low_cycles = 0, late_ready = 0;
    bit            gap_used = 1'b0;
    logic [WW-1:0] w, obs, expv;
    word_q.delete();
    clear_chain(BS);
    apply_stimulus(1'b0);
    for (int c = 0; c < 4 * BS && done_at < 0; c++) begin
      if (bus.done) done_at = cyc;
      else if (first >= 0 && !bus.config_enable) low_cycles++;
      if (bus.config_enable && first < 0) first = cyc;
      if (idx == NWORDS && bus.word_ready) late_ready++;
      if (reset_at > 0 && int'(bus.shift_count) == reset_at) begin
        check_reset_abort(name);
        word_q.delete();
        return;
      end
      if (!gap_used && gap_len > 0 && idx == gap_word && bus.word_ready) begin
        gap_left = gap_len;
        gap_used = 1'b1;
      end
      bus.word_valid = (idx < NWORDS) && (gap_left == 0);
      if (idx < NWORDS) bus.word_data = words[idx];
      if (gap_left > 0) gap_left--;
      if (bus.word_valid && bus.word_ready) begin
        if (idx == 0) xfer0 = cyc;
        word_q.push_back(words[idx]);
        idx++;
      end
      @(negedge prog_clk);
    end
    bus.word_valid = 1'b0;
    check_output({name, "_done_seen"},         done_at >= 0, 1);
    check_output({name, "_first_bit_latency"}, first - xfer0, 2);
    check_output({name, "_done_latency"},      done_at - first, BS + exp_stall);
    check_output({name, "_stall_cycles"},      low_cycles, exp_stall);
    check_output({name, "_transfers"},         idx, NWORDS);
    check_output({name, "_ready_after_last"},  late_ready, 0);
    check_output({name, "_count"},             bus.shift_count, BS);
    check_output({name, "_error"},             bus.error, 0);
    // Bit i of the stream (MSB of word 0 first) ends in chain position BS-1-i.
    for (int j = 0; j < NWORDS; j++) begin
      w    = word_q.pop_front();
      obs  = '0;
      expv = '0;
      for (int b = 0; b < WW; b++) begin
        if (j * WW + b < BS) begin
          obs[WW-1-b]  = chain[BS-1-(j*WW+b)];
          expv[WW-1-b] = w[WW-1-b];
        end
      end
      check_output($sformatf("%s_chain_word%0d", name, j), obs, expv);
    end
    @(negedge prog_clk);
    check_output({name, "_idle_after_done"}, bus.busy, 0);
  endtask

  initial begin
    prog_reset     = 1'b1;
    bus.start      = 1'b0;
    bus.test_mode  = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    chain_clear    = 1'b1;
    chain_len      = BS;
    tail_broken    = 1'b0;
    for (int j = 0; j < NWORDS; j++) words[j] = $urandom;
    repeat (3) @(negedge prog_clk);
    check_output("reset_enable", bus.config_enable, 0);
    check_output("reset_head",   bus.ccff_head, 0);
    check_output("reset_busy",   bus.busy, 0);
    check_output("reset_done",   bus.done, 0);
    check_output("reset_error",  bus.error, 0);
    check_output("reset_count",  bus.shift_count, 0);
    check_output("reset_ready",  bus.word_ready, 0);
    prog_reset  = 1'b0;
    chain_clear = 1'b0;

    run_test("selftest_pass", BS,     1'b0, 1'b0, BS);
    run_test("selftest_short", BS - 1, 1'b0, 1'b1, BS - 1);
    run_test("selftest_broken", BS,   1'b1, 1'b1, BS);

    run_prog("prog_stream",    0,  0,      0, 0);
    run_prog("prog_underflow", 10, WW + 4, 5, 0);
    run_prog("prog_abort",     0,  0,      0, 1000);
    run_prog("prog_restart",   0,  0,      0, 0);

    @(negedge prog_clk);
    prog_reset    = 1'b1;
    bus.start     = 1'b1;
    bus.test_mode = 1'b1;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    bus.start  = 1'b0;
    check_output("reset_beats_start_busy",   bus.busy, 0);
    check_output("reset_beats_start_enable", bus.config_enable, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
